// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem read, the IF/ID pipeline register and a
// one-entry hold buffer for a response that lands while ID is stalled.
module if_fetch #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] pc_4,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_4,
   output logic        ifid_adel
);

   typedef enum logic [1:0] {StFetch, StWait, StHold, StKill} state_e;

   state_e      state_q, state_d;
   logic [31:0] buf_q, buf_d;
   logic        busy;
   logic        load_mem;
   logic        load_buf;

   assign busy      = ifid_valid & stall;
   assign imem_addr = {pc[31:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: begin
            if (!redirect) state_d = StWait;
         end
         StWait: begin
            if (redirect) begin
               state_d = imem_rvalid ? StFetch : StKill;
            end else if (imem_rvalid) begin
               state_d = busy ? StHold : StFetch;
            end
         end
         StHold: begin
            if (redirect || !stall) state_d = StFetch;
         end
         StKill: begin
            if (imem_rvalid) state_d = StFetch;
         end
         default: state_d = StFetch;
      endcase
   end

   // Reset forces the combinational outputs too, so the abandon is visible in the same cycle.
   always_comb begin
      pc_next  = pc;
      imem_req = 1'b0;
      load_mem = 1'b0;
      load_buf = 1'b0;
      buf_d    = buf_q;
      if (!rst) begin
         unique case (state_q)
            StFetch: begin
               if (redirect) pc_next = redirect_pc;
               else          imem_req = 1'b1;
            end
            StWait: begin
               if (redirect) begin
                  pc_next = redirect_pc;
               end else if (imem_rvalid) begin
                  if (busy) begin
                     buf_d = imem_rdata;
                  end else begin
                     load_mem = 1'b1;
                     pc_next  = pc_4;
                  end
               end
            end
            StHold: begin
               if (redirect) begin
                  pc_next = redirect_pc;
               end else if (!stall) begin
                  load_buf = 1'b1;
                  pc_next  = pc_4;
               end
            end
            StKill: begin
               if (redirect) pc_next = redirect_pc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q      <= '0;
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= '0;
         ifid_pc_4  <= '0;
         ifid_adel  <= 1'b0;
      end else begin
         buf_q <= buf_d;
         if (redirect) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
         end else if (!busy) begin
            if (load_mem || load_buf) begin
               ifid_valid <= 1'b1;
               ifid_instr <= load_buf ? buf_q : imem_rdata;
               ifid_pc    <= pc;
               ifid_pc_4  <= pc_4;
               ifid_adel  <= |pc[1:0];
            end else begin
               ifid_valid <= 1'b0;
               ifid_instr <= NOP_INSTR;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a transaction-level memory plus an in-order instruction
// stream scoreboard (next expected pc, redirect targets) judge every IF/ID update.
module tb_if_fetch;

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, pc_4, pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall, redirect;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc_4;
   logic        ifid_adel;

   always #5 clk = ~clk;

   if_fetch #(.NOP_INSTR(Nop)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_4       (pc_4),
      .pc_next    (pc_next),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .ifid_valid (ifid_valid),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .ifid_pc_4  (ifid_pc_4),
      .ifid_adel  (ifid_adel)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit          pending, stale, first_cycle, inject_late;
   int          lat_left;
   logic [31:0] pending_addr;
   logic [31:0] exp_pc;
   int          deliveries, cov_adel, cov_wrap;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h3000) return 32'h2408_0001;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic reset_checks();
      check("rst_imem_req", 32'(imem_req), 0);
      check("rst_pc_next", pc_next, pc);
      check("rst_ifid_valid", 32'(ifid_valid), 0);
      check("rst_ifid_instr", ifid_instr, Nop);
      check("rst_ifid_pc", ifid_pc, 0);
      check("rst_ifid_pc_4", ifid_pc_4, 0);
      check("rst_ifid_adel", 32'(ifid_adel), 0);
   endtask

   // Asserts rst mid-cycle, holds it across one edge, releases right after that edge.
   task automatic do_reset(input bit late);
      @(negedge clk);
      rst         = 1'b1;
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      stall       = 1'b0;
      #1;
      reset_checks();
      @(posedge clk);
      #1;
      reset_checks();
      rst         = 1'b0;
      pending     = 1'b0;
      stale       = 1'b0;
      exp_pc      = pc;
      first_cycle = 1'b1;
      inject_late = late;
   endtask

   task automatic do_cycle(input int p_stall, input int p_redir, input int max_lat);
      logic        rv, pre_valid, pre_stall, pre_redir, pre_adel;
      logic [31:0] rpc, pre_instr, pre_pc, pre_pc4, nxt;
      @(negedge clk);
      rv          = (pending && lat_left == 0) || inject_late;
      imem_rvalid = rv;
      imem_rdata  = (rv && !inject_late && !stale) ? mem_word(pending_addr) : $urandom();
      stall       = int'($urandom_range(99)) < p_stall;
      redirect    = int'($urandom_range(99)) < p_redir;
      case ($urandom_range(7))
         0:       rpc = 32'hFFFF_FFFC;
         1:       rpc = 32'h3000 + 32'($urandom_range(255));
         default: rpc = 32'h4000 + (32'($urandom_range(1023)) << 2);
      endcase
      redirect_pc = rpc;
      #1;
      check("imem_addr", imem_addr, {pc[31:2], 2'b00});
      if (imem_req) begin
         check("req_while_outstanding", 32'(pending), 0);
         check("req_addr_in_order", imem_addr, {exp_pc[31:2], 2'b00});
      end
      if (first_cycle && !redirect) check("first_req_after_reset", 32'(imem_req), 1);
      if (redirect)                       check("pc_next_redirect", pc_next, redirect_pc);
      else if (rv && pending && !stale)   check("pc_next_on_rvalid", pc_next,
                                                (ifid_valid && stall) ? pc : pc_4);
      else if (rv)                        check("pc_next_stale_rvalid", pc_next, pc);
      pre_valid = ifid_valid;
      pre_stall = stall;
      pre_redir = redirect;
      pre_adel  = ifid_adel;
      pre_instr = ifid_instr;
      pre_pc    = ifid_pc;
      pre_pc4   = ifid_pc_4;
      nxt       = pc_next;
      if (rv) begin
         pending = 1'b0;
         stale   = 1'b0;
      end else if (pending) begin
         lat_left--;
      end
      if (redirect) begin
         exp_pc = redirect_pc;
         if (pending) stale = 1'b1;
      end
      if (imem_req) begin
         pending      = 1'b1;
         stale        = 1'b0;
         lat_left     = int'($urandom_range(max_lat));
         pending_addr = imem_addr;
      end
      inject_late = 1'b0;
      first_cycle = 1'b0;
      @(posedge clk);
      #1;
      pc   = nxt;
      pc_4 = nxt + 32'd4;
      if (pre_redir) begin
         check("ifid_valid_after_redirect", 32'(ifid_valid), 0);
      end else if (pre_valid && pre_stall) begin
         check("hold_valid", 32'(ifid_valid), 1);
         check("hold_instr", ifid_instr, pre_instr);
         check("hold_pc", ifid_pc, pre_pc);
      end else if (ifid_valid) begin
         check("ifid_pc_in_order", ifid_pc, exp_pc);
         check("ifid_instr", ifid_instr, mem_word({exp_pc[31:2], 2'b00}));
         check("ifid_pc_4", ifid_pc_4, exp_pc + 32'd4);
         check("ifid_adel", 32'(ifid_adel), 32'(exp_pc[1:0] != 2'b00));
         if (exp_pc[1:0] != 2'b00)  cov_adel++;
         if (exp_pc + 32'd4 == '0)  cov_wrap++;
         exp_pc = exp_pc + 32'd4;
         deliveries++;
      end
      if (!ifid_valid) begin
         check("nop_when_invalid", ifid_instr, Nop);
         check("bubble_keeps_pc", ifid_pc, pre_pc);
         check("bubble_keeps_pc_4", ifid_pc_4, pre_pc4);
         check("bubble_keeps_adel", 32'(ifid_adel), 32'(pre_adel));
      end
   endtask

   initial begin
      int d0, ps, pr;
      rst         = 1'b1;
      pc          = 32'h3000;
      pc_4        = 32'h3004;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pending     = 1'b0;
      stale       = 1'b0;
      lat_left    = 0;
      deliveries  = 0;
      cov_adel    = 0;
      cov_wrap    = 0;
      do_reset(1'b0);

      // First fetch from 0x3000 with one-cycle memory latency.
      do_cycle(0, 0, 0);
      do_cycle(0, 0, 0);
      check("first_valid", 32'(ifid_valid), 1);
      check("first_instr", ifid_instr, 32'h2408_0001);
      check("first_pc", ifid_pc, 32'h3000);
      check("first_pc_4", ifid_pc_4, 32'h3004);
      check("first_pc_reg", pc, 32'h3004);

      // One instruction every two cycles with 1-cycle latency and no stalls.
      do_reset(1'b0);
      d0 = deliveries;
      for (int i = 0; i < 40; i++) do_cycle(0, 0, 0);
      check("throughput", 32'(deliveries - d0), 20);

      // Reset mid-WAIT, then a late response for the abandoned request.
      do_reset(1'b0);
      do_cycle(0, 0, 3);
      do_reset(1'b1);
      d0 = deliveries;
      for (int i = 0; i < 8; i++) do_cycle(0, 0, 0);
      check("delivers_after_late_rvalid", 32'(deliveries - d0), 4);

      d0 = deliveries;
      for (int i = 0; i < 3000; i++) begin
         ps = ((i / 500) % 2 == 0) ? 25 : 60;
         pr = ((i / 250) % 2 == 0) ? 4 : 15;
         if ($urandom_range(199) == 0) do_reset(pending);
         else                          do_cycle(ps, pr, 3);
      end
      check("random_progress", 32'(deliveries - d0 > 200), 1);
      check("saw_misaligned", 32'(cov_adel > 0), 1);
      check("saw_pc_wrap", 32'(cov_wrap > 0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have one parameter: NOP_INSTR, default 32'h0000_0000, the value ifid_instr carries whenever ifid_valid=0.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 pc  in  32  current PC from the PC register.
REQ-006 pc_4  in  32  pc+4 from the PC register.
REQ-007 pc_next  out  32  combinational value loaded into the PC register every cycle.
REQ-008 imem_req  out  1  one-cycle instruction-read request.
REQ-009 imem_addr  out  32  {pc[31:2],2'b00}.
REQ-010 imem_rvalid  in  1  read data valid; exactly one per request, at least 1 cycle after it.
REQ-011 imem_rdata  in  32  instruction word, sampled only when imem_rvalid=1.
REQ-012 stall  in  1  ID stage cannot accept; hold IF/ID.
REQ-013 redirect  in  1  taken branch/jump from EX; no delay slot.
REQ-014 redirect_pc  in  32  redirect target.
REQ-015 ifid_valid, ifid_instr[31:0], ifid_pc[31:0], ifid_pc_4[31:0], ifid_adel  out  IF/ID register; ifid_adel flags pc[1:0]!=0.

Function
REQ-016 SHALL implement states FETCH, WAIT, HOLD, KILL, with a 32-bit hold buffer.
REQ-017 FETCH: redirect=1 -> imem_req=0, pc_next=redirect_pc, stay; else imem_req=1, pc_next=pc, -> WAIT.
REQ-018 WAIT, no rvalid, no redirect: pc_next=pc, stay.
REQ-019 WAIT, rvalid, no redirect, IF/ID free (ifid_valid=0 or stall=0): load IF/ID {1, rdata, pc, pc_4, pc[1:0]!=0}, pc_next=pc_4, -> FETCH.
REQ-020 WAIT, rvalid, no redirect, IF/ID busy (ifid_valid=1 and stall=1): rdata -> buffer, pc_next=pc, -> HOLD.
REQ-021 WAIT, redirect with no rvalid: pc_next=redirect_pc, -> KILL; redirect with rvalid the same cycle: drop rdata, pc_next=redirect_pc, -> FETCH.
REQ-022 KILL: pc_next=pc; rvalid -> discard, -> FETCH; a repeated redirect -> pc_next=redirect_pc, stay KILL.
REQ-023 HOLD: stall=1 -> pc_next=pc, stay; stall=0 -> buffer to IF/ID with pc/pc_4, pc_next=pc_4, -> FETCH; redirect -> discard buffer, pc_next=redirect_pc, -> FETCH.
REQ-024 IF/ID update priority SHALL be redirect (ifid_valid<=0) > stall (hold all) > new load > bubble (ifid_valid<=0).
REQ-025 When ifid_valid is cleared, ifid_instr SHALL be NOP_INSTR; ifid_pc, ifid_pc_4 and ifid_adel SHALL hold their values.
REQ-026 At most one request SHALL be outstanding; imem_req SHALL never assert outside FETCH.
REQ-027 Steady-state throughput with 1-cycle memory latency and no stall SHALL be one instruction per 2 cycles.
REQ-028 pc wrap 32'hFFFF_FFFC -> pc_4 0 SHALL be passed through unmodified.
REQ-029 A misaligned pc SHALL still fetch and deliver, with ifid_adel=1.

Reset
REQ-030 While rst=1: state=FETCH, imem_req=0, buffer cleared, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_4=0, ifid_adel=0, pc_next=pc.
REQ-031 Reset asserted mid-WAIT or mid-KILL SHALL abandon the transaction; a late imem_rvalid in FETCH after reset SHALL be ignored.
REQ-032 The first request SHALL issue in the first cycle after rst deasserts.

Verification
REQ-033 pc=0x3000, rvalid 1 cycle after req with rdata=0x2408_0001 -> ifid {1, 0x24080001, 0x3000, 0x3004}; pc_next=0x3004 on the rvalid cycle.
REQ-034 IF/ID holds 0x3000 with stall=1 for 3 cycles, response for 0x3004 arrives -> HOLD, pc_next=0x3004; stall drops -> ifid_pc=0x3004 on the next edge.
REQ-035 redirect=1 to 0x3100 while in WAIT with no rvalid -> KILL; the stale rvalid is dropped; next imem_addr=0x3100; ifid_valid=0.
REQ-036 redirect and rvalid in the same WAIT cycle, with stall=1 -> ifid_valid<=0, pc_next=redirect_pc, state FETCH.
REQ-037 pc=0x3002 -> imem_addr=0x3000, ifid_adel=1; pc=0xFFFF_FFFC -> ifid_pc_4=0.
REQ-038 rst pulsed during WAIT -> all outputs at reset values within the same cycle; a late rvalid is ignored.
